seq_adder_nbit: RTL and testbench

Parametrised multi-cycle adder/subtractor, successor to the combinational 4-bit adder. It adds two WIDTH-bit operands CHUNK bits per clock, LSB chunk first, under a start/done handshake. Outputs are carry-out and signed overflow, and it supports an add/subtract mode. It serves datapaths that need wide arithmetic with a small ripple slice per cycle.

---
 rtl/seq_adder_nbit.sv | 94 +++++++++
 tb/tb_seq_adder_nbit.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_adder_nbit.sv
// Multi-cycle WIDTH-bit adder/subtractor: ripples CHUNK bits per clock, LSB chunk first,
// under a start/busy/done handshake with carry-out and signed-overflow flags.
module seq_adder_nbit #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_r, b_r, psum, psum_nxt;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [CHUNK-1:0] ach, bch;
    logic [CHUNK:0]   csum;
    logic             accept, last, msb_cin;

    assign accept = (state == IDLE) && start;
    assign last   = (cnt == CW'(NCHUNK - 1));
    assign busy   = (state == RUN);

    // One CHUNK-wide ripple slice; the partial sum keeps results away from sum until the end.
    always_comb begin
        ach      = a_r[cnt*CHUNK +: CHUNK];
        bch      = b_r[cnt*CHUNK +: CHUNK];
        csum     = {1'b0, ach} + {1'b0, bch} + {{CHUNK{1'b0}}, carry};
        psum_nxt = psum;
        psum_nxt[cnt*CHUNK +: CHUNK] = csum[CHUNK-1:0];
        // Carry into the top bit of the slice, recovered from its sum bit.
        msb_cin  = ach[CHUNK-1] ^ bch[CHUNK-1] ^ csum[CHUNK-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r   <= '0;
            b_r   <= '0;
            psum  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                // Subtraction is A + ~B + 1, so invert B once here and seed the carry.
                a_r   <= a;
                b_r   <= mode ? ~b : b;
                carry <= mode ? 1'b1 : cin;
                cnt   <= '0;
            end else if (state == RUN) begin
                psum  <= psum_nxt;
                carry <= csum[CHUNK];
                cnt   <= cnt + 1'b1;
                if (last) begin
                    sum  <= psum_nxt;
                    cout <= csum[CHUNK];
                    ovf  <= msb_cin ^ csum[CHUNK];
                    done <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_seq_adder_nbit.sv
// Bench for seq_adder_nbit: 16/4 and 4/1 instances, directed literal cases plus
// randomized traffic compared every cycle against a transaction-level model.
module tb_seq_adder_nbit;
    localparam int W   = 16;
    localparam int C   = 4;
    localparam int NCH = W / C;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start, mode, cin, busy, done, cout, ovf;
    logic [15:0] a, b, sum;
    logic        s4_start, s4_mode, s4_cin, s4_busy, s4_done, s4_cout, s4_ovf;
    logic [3:0]  s4_a, s4_b, s4_sum;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    seq_adder_nbit #(.WIDTH(W), .CHUNK(C)) u16 (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf));

    seq_adder_nbit #(.WIDTH(4), .CHUNK(1)) u4 (
        .clk(clk), .rst_n(rst_n), .start(s4_start), .mode(s4_mode), .a(s4_a), .b(s4_b),
        .cin(s4_cin), .busy(s4_busy), .done(s4_done), .sum(s4_sum), .cout(s4_cout),
        .ovf(s4_ovf));

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Returns {ovf, cout, sum} of a w-bit add/subtract from plain integer arithmetic.
    function automatic logic [17:0] ref_calc(input int w, input logic [15:0] ra, rb,
                                             input logic rcin, rmode);
        logic [63:0] mask, av, bv, full, s;
        logic co, ov;
        mask = (64'd1 << w) - 64'd1;
        av   = {48'd0, ra} & mask;
        bv   = rmode ? (~{48'd0, rb}) & mask : {48'd0, rb} & mask;
        full = av + bv + (rmode ? 64'd1 : {63'd0, rcin});
        s    = full & mask;
        co   = full[w];
        ov   = (av[w-1] == bv[w-1]) && (s[w-1] != av[w-1]);
        return {ov, co, s[15:0]};
    endfunction

    // Transaction model of the 16-bit instance: an accepted op completes NCH edges later.
    int          m_rem  = 0;
    logic        m_busy = 1'b0, m_done = 1'b0, m_cout = 1'b0, m_ovf = 1'b0;
    logic [15:0] m_sum  = '0;
    logic [17:0] m_pend = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rem = 0; m_busy = 0; m_done = 0; m_sum = '0; m_cout = 0; m_ovf = 0;
        end else begin
            m_done = 1'b0;
            if (m_rem > 0) begin
                m_rem--;
                if (m_rem == 0) begin
                    {m_ovf, m_cout, m_sum} = m_pend;
                    m_done = 1'b1;
                end
            end else if (start) begin
                m_pend = ref_calc(W, a, b, cin, mode);
                m_rem  = NCH;
            end
            m_busy = (m_rem > 0);
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("cyc_busy", {31'd0, busy}, {31'd0, m_busy});
            check("cyc_done", {31'd0, done}, {31'd0, m_done});
            check("cyc_sum",  {16'd0, sum},  {16'd0, m_sum});
            check("cyc_cout", {31'd0, cout}, {31'd0, m_cout});
            check("cyc_ovf",  {31'd0, ovf},  {31'd0, m_ovf});
        end
    end

    task automatic run16(input logic [15:0] ta, tb, input logic tcin, tmode, output int lat);
        a = ta; b = tb; cin = tcin; mode = tmode; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); mode = 1'($urandom);
        lat = 0;
        while (done !== 1'b1 && lat < 12) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic pin16(input string name, input logic [15:0] ta, tb, input logic tcin, tmode,
                         input logic [15:0] es, input logic ec, eo);
        int lat;
        run16(ta, tb, tcin, tmode, lat);
        check({name, "_lat"},  lat, NCH);
        check({name, "_sum"},  {16'd0, sum},  {16'd0, es});
        check({name, "_cout"}, {31'd0, cout}, {31'd0, ec});
        check({name, "_ovf"},  {31'd0, ovf},  {31'd0, eo});
        @(negedge clk);
        check({name, "_pulse"}, {31'd0, done}, 32'd0);
    endtask

    task automatic run4(input logic [3:0] ta, tb, input logic tcin, tmode);
        int lat;
        logic [17:0] e;
        e = ref_calc(4, {12'd0, ta}, {12'd0, tb}, tcin, tmode);
        s4_a = ta; s4_b = tb; s4_cin = tcin; s4_mode = tmode; s4_start = 1'b1;
        @(negedge clk);
        s4_start = 1'b0;
        s4_a = 4'($urandom); s4_b = 4'($urandom); s4_cin = 1'($urandom);
        s4_mode = 1'($urandom);
        lat = 0;
        while (s4_done !== 1'b1 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check("r4_lat",  lat, 4);
        check("r4_sum",  {28'd0, s4_sum},  {28'd0, e[3:0]});
        check("r4_cout", {31'd0, s4_cout}, {31'd0, e[16]});
        check("r4_ovf",  {31'd0, s4_ovf},  {31'd0, e[17]});
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int lat, n, t_first;
        rst_n = 1'b0; start = 0; mode = 0; cin = 0; a = '0; b = '0;
        s4_start = 0; s4_mode = 0; s4_cin = 0; s4_a = '0; s4_b = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_sum",  {16'd0, sum},  32'd0);
        check("rst_cout", {31'd0, cout}, 32'd0);
        check("rst_ovf",  {31'd0, ovf},  32'd0);
        check("rst4_sum", {28'd0, s4_sum}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 4-bit, 1-bit chunks: 1 + 6 + 1 overflows into the sign bit.
        s4_a = 4'd1; s4_b = 4'd6; s4_cin = 1'b1; s4_mode = 1'b0; s4_start = 1'b1;
        @(negedge clk);
        s4_start = 1'b0;
        check("t1_busy0", {31'd0, s4_busy}, 32'd1);
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            check("t1_busy", {31'd0, s4_busy}, 32'd1);
            check("t1_nodone", {31'd0, s4_done}, 32'd0);
        end
        @(negedge clk);
        check("t1_done", {31'd0, s4_done}, 32'd1);
        check("t1_idle", {31'd0, s4_busy}, 32'd0);
        check("t1_sum",  {28'd0, s4_sum},  32'h8);
        check("t1_cout", {31'd0, s4_cout}, 32'd0);
        check("t1_ovf",  {31'd0, s4_ovf},  32'd1);
        @(negedge clk);
        check("t1_pulse", {31'd0, s4_done}, 32'd0);
        check("t1_hold",  {28'd0, s4_sum},  32'h8);
        for (int i = 0; i < 40; i++)
            run4(4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));

        pin16("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        pin16("add_ovf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        pin16("sub_brw",  16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        pin16("sub_ovf",  16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

        // A start pulsed mid-operation must be ignored.
        a = 16'h1234; b = 16'h1111; cin = 0; mode = 0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 16'hFFFF; b = 16'hFFFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 2;
        while (done !== 1'b1 && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        check("ign_lat", lat, NCH);
        check("ign_sum", {16'd0, sum}, 32'h2345);
        t_first = cyc;

        // Back-to-back: start in the done cycle.
        a = 16'h0100; b = 16'h0200; cin = 0; mode = 0; start = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) start = 1'b0;
            if (n == 2) check("b2b_hold", {16'd0, sum}, 32'h2345);
        end while (done !== 1'b1 && n < 12);
        check("b2b_gap", n, NCH + 1);
        check("b2b_cyc", cyc - t_first, NCH + 1);
        check("b2b_sum", {16'd0, sum}, 32'h0300);
        @(negedge clk);
        check("b2b_pulse", {31'd0, done}, 32'd0);

        // Asynchronous reset in the middle of an operation.
        a = 16'hAAAA; b = 16'h5555; cin = 0; mode = 0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        check("mid_rst_sum",  {16'd0, sum},  32'd0);
        check("mid_rst_cout", {31'd0, cout}, 32'd0);
        check("mid_rst_ovf",  {31'd0, ovf},  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("post_rst_nodone", {31'd0, done}, 32'd0);
        end
        pin16("post_rst", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);

        // Random traffic with stray starts while busy; per-cycle model does the checking.
        for (int i = 0; i < 150; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); mode = 1'($urandom);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            n = 0;
            while (done !== 1'b1 && n < NCH + 3) begin
                @(negedge clk);
                n++;
                if (done !== 1'b1 && $urandom_range(0, 3) == 0) begin
                    start = 1'b1;
                    a = 16'($urandom); b = 16'($urandom);
                end else begin
                    start = 1'b0;
                end
            end
            start = 1'b0;
            if (done !== 1'b1) check("rand_timeout", {31'd0, done}, 32'd1);
        end
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
